// File: rtl/univ_reg_pkg.sv
// Shared constants for the universal register.
// MODE_W        : width of the mode select field.
// MODE_*        : operation codes decoded by univ_reg_next.
package univ_reg_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_reg_next.sv
// Combinational next-state logic for univ_reg.
// Ports:
//   mode_i  : operation select
//   q_i     : current register contents
//   d_i     : parallel load data
//   sin_l_i : serial input into the MSB (SHR)
//   sin_r_i : serial input into the LSB (SHL)
//   q_o     : next register contents
//   sout_o  : next shifted/rotated-out bit
//   cout_o  : next carry (INC) or borrow (DEC)
// HOLD returns q unchanged with zero flags; the top level skips the flop update
// for HOLD so the stored sout/cout are preserved.
import univ_reg_pkg::*;

module univ_reg_next #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  q_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic              sin_l_i,
    input  logic              sin_r_i,
    output logic [WIDTH-1:0]  q_o,
    output logic              sout_o,
    output logic              cout_o
);

    logic [WIDTH:0] one_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Carry and borrow come from the extra top bit of a WIDTH+1-bit result.
    always_comb begin
        one_ext = {{WIDTH{1'b0}}, 1'b1};
        sum     = {1'b0, q_i} + one_ext;
        diff    = {1'b0, q_i} - one_ext;
    end

    always_comb begin
        q_o    = q_i;
        sout_o = 1'b0;
        cout_o = 1'b0;
        case (mode_i)
            MODE_HOLD: ;
            MODE_LOAD: q_o = d_i;
            MODE_SHL: begin
                q_o    = {q_i[WIDTH-2:0], sin_r_i};
                sout_o = q_i[WIDTH-1];
            end
            MODE_SHR: begin
                q_o    = {sin_l_i, q_i[WIDTH-1:1]};
                sout_o = q_i[0];
            end
            MODE_ROL: begin
                q_o    = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                sout_o = q_i[WIDTH-1];
            end
            MODE_ROR: begin
                q_o    = {q_i[0], q_i[WIDTH-1:1]};
                sout_o = q_i[0];
            end
            MODE_INC: begin
                q_o    = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
            end
            MODE_DEC: begin
                q_o    = diff[WIDTH-1:0];
                cout_o = diff[WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_reg.sv
// Universal register: hold, load, shift, rotate, increment and decrement with
// registered shift-out and carry/borrow status.
// Ports:
//   ck    : clock, rising edge
//   rst   : synchronous active-high reset (overrides en and mode)
//   en    : operation enable; 0 holds all state
//   mode  : operation select (see univ_reg_pkg)
//   d     : parallel load data
//   sin_r : serial bit into bit 0 on SHL
//   sin_l : serial bit into bit WIDTH-1 on SHR
//   q     : register contents
//   sout  : registered shifted/rotated-out bit of the last enabled op
//   cout  : registered carry/borrow of the last enabled op
//   zero  : combinational, 1 iff q == 0
import univ_reg_pkg::*;

module univ_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_r,
    input  logic              sin_l,
    output logic [WIDTH-1:0]  q,
    output logic              sout,
    output logic              cout,
    output logic              zero
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             cout_q, cout_d;
    logic             upd;

    univ_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .mode_i  (mode),
        .q_i     (q_q),
        .d_i     (d),
        .sin_l_i (sin_l),
        .sin_r_i (sin_r),
        .q_o     (q_d),
        .sout_o  (sout_d),
        .cout_o  (cout_d)
    );

    // HOLD must keep sout/cout, so it is treated like a disabled cycle.
    assign upd = en && (mode != MODE_HOLD);

    always_ff @(posedge ck) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            sout_q <= 1'b0;
            cout_q <= 1'b0;
        end else if (upd) begin
            q_q    <= q_d;
            sout_q <= sout_d;
            cout_q <= cout_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign cout = cout_q;
    assign zero = (q_q == '0);

endmodule
